// File: rtl/eq1_result_quantizer.sv
// Requantizes the eq1 Q(2N,2*FRAC) sum to Q(N,FRAC) with saturation, behind an S1 register and 2-entry FIFO.
// Latency 2 cycles, 1 word/cycle; in_ready combinational from out_ready. EQ1Q_ROUND_EN: round-half-up.
module eq1_result_quantizer #(
  parameter int N     = 20,
  parameter int FRAC  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             cnt_clr
);

`ifdef EQ1Q_ROUND_EN
  localparam logic signed [2*N:0] BIAS = {{(2*N){1'b0}}, 1'b1} << (FRAC - 1);
`else
  localparam logic signed [2*N:0] BIAS = '0;
`endif
  localparam logic signed [2*N:0] Q_MAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] Q_MIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  logic signed [2*N:0] v;
  logic signed [2*N:0] q;
  logic [N-1:0]        q_data;
  logic                q_sat;

  always_comb begin
    v      = $signed({in_full[2*N-1], in_full}) + BIAS;
    q      = v >>> FRAC;
    q_data = q[N-1:0];
    q_sat  = 1'b0;
    if (q > Q_MAX) begin
      q_data = Q_MAX[N-1:0];
      q_sat  = 1'b1;
    end else if (q < Q_MIN) begin
      q_data = Q_MIN[N-1:0];
      q_sat  = 1'b1;
    end
  end

  // Holds in_ready low during reset and for the first edge after release.
  logic alive;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  logic         s1_valid;
  logic [N-1:0] s1_data;
  logic         s1_sat;
  logic [N:0]   mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   fifo_cnt;
  logic         fifo_full;
  logic         pop;
  logic         push;
  logic         load;

  assign out_valid = (fifo_cnt != 2'd0);
  assign fifo_full = (fifo_cnt == 2'd2);
  assign pop       = out_valid & out_ready;
  assign push      = s1_valid & (~fifo_full | pop);
  assign in_ready  = alive & (~s1_valid | ~fifo_full | pop);
  assign load      = in_valid & in_ready;
  assign {out_sat, out_data} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= load | (s1_valid & ~push);
      if (load) begin
        s1_data <= q_data;
        s1_sat  <= q_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= {s1_sat, s1_data};
      wr_ptr   <= wr_ptr ^ push;
      rd_ptr   <= rd_ptr ^ pop;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Clear wins over a plain hold, but a saturating load in the same cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= (load & q_sat) ? CNT_W'(1) : '0;
    end else if (load & q_sat & ~(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_eq1_result_quantizer.sv
// Scoreboard bench for eq1_result_quantizer; reference model uses plain integer floor division and clamping.
module tb_eq1_result_quantizer;
  localparam int N     = 20;
  localparam int FRAC  = 10;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_full;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             out_sat;
  logic [CNT_W-1:0] sat_cnt;
  logic             cnt_clr;

  always #5 clk = ~clk;

  eq1_result_quantizer #(.N(N), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_full(in_full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  typedef struct packed {
    logic [N-1:0] d;
    logic         s;
  } exp_t;

  exp_t q_exp[$];
  int   tests = 0;
  int   fails = 0;
  int   model_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [2*N-1:0] f);
    longint v, r, q, d, hi, lo;
    exp_t   e;
    d  = longint'(1) << FRAC;
    v  = longint'($signed(f));
`ifdef EQ1Q_ROUND_EN
    v  = v + d / 2;
`endif
    r  = v % d;
    if (r < 0) r = r + d;
    q  = (v - r) / d;
    hi = (longint'(1) << (N - 1)) - 1;
    lo = -hi - 1;
    e.s = 1'b1;
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    else             e.s = 1'b0;
    e.d = N'(q);
    return e;
  endfunction

  function automatic logic [2*N-1:0] rand_full();
    logic [2*N-1:0] t;
    longint b;
    t = (2*N)'({$urandom(), $urandom()});
    case ($urandom_range(0, 3))
      0: return t;
      1: return {{10{t[29]}}, t[29:0]};
      2: return {{20{t[19]}}, t[19:0]};
      default: begin
        b = (longint'(1) << 29) + longint'($urandom_range(0, 2047)) - 1024;
        if ($urandom_range(0, 1) == 1) b = -b;
        return (2*N)'(b);
      end
    endcase
  endfunction

  // One clock cycle of stimulus; called right after a falling edge, returns after the next one.
  task automatic cycle(input bit iv, input logic [2*N-1:0] f, input bit ordy, input bit clr,
                       output bit acc);
    exp_t e;
    in_valid  = iv;
    in_full   = iv ? f : (2*N)'({$urandom(), $urandom()});
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    acc = iv && in_ready;
    e   = ref_model(f);
    if (acc) q_exp.push_back(e);
    @(posedge clk);
    if (clr)                               model_cnt = (acc && e.s) ? 1 : 0;
    else if (acc && e.s && model_cnt < 15) model_cnt++;
    @(negedge clk);
    check("sat_cnt", sat_cnt, model_cnt);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (q_exp.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q_exp[0];
          check("out_data", out_data, e.d);
          check("out_sat", out_sat, e.s);
          if (out_ready) void'(q_exp.pop_front());
        end
      end
    end
  end

  initial begin
    bit   acc;
    int   n_acc;
    logic [2*N-1:0] w;
    logic [2*N-1:0] sat_word;
    sat_word  = {2'b01, {(2*N-2){1'b1}}};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_full   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    // Latency: word accepted on one edge is visible after the following edge.
    w = 40'sd3145728;
    cycle(1, w, 1, 0, acc);
    check("t1_accept", acc, 1);
    check("t1_lat_s1", out_valid, 0);
    cycle(0, '0, 1, 0, acc);
    check("t1_lat_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 3072);
    repeat (3) cycle(0, '0, 1, 0, acc);

    w = 40'sd536870912;
    cycle(1, w, 1, 0, acc);
    w = -40'sd536872960;
    cycle(1, w, 1, 0, acc);
    w = 40'sd1536;
    cycle(1, w, 1, 0, acc);
    w = -40'sd1536;
    cycle(1, w, 1, 0, acc);
    repeat (4) cycle(0, '0, 1, 0, acc);
    check("t2_sat_cnt", sat_cnt, 2);

    // Backpressure: S1 plus two FIFO entries hold three words.
    n_acc = 0;
    for (int i = 1; i <= 4; i++) begin
      cycle(1, (2*N)'(i * 10 * 1024), 0, 0, acc);
      n_acc += int'(acc);
    end
    check("bp_accepted", n_acc, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_head", out_data, 10);
    repeat (2) cycle(1, (2*N)'(40 * 1024), 0, 0, acc);
    check("bp_hold_data", out_data, 10);
    for (int i = 0; i < 4; i++) begin
      check("bp_consecutive", out_valid, 1);
      cycle(i == 0, (2*N)'(40 * 1024), 1, 0, acc);
      if (i == 0) check("bp_accept_40", acc, 1);
    end
    repeat (3) cycle(0, '0, 1, 0, acc);

    // Counter saturation and clear-with-load.
    repeat (20) cycle(1, sat_word, 1, 0, acc);
    check("cnt_stick", sat_cnt, 15);
    cycle(1, sat_word, 1, 1, acc);
    check("cnt_clr_load", sat_cnt, 1);
    cycle(0, '0, 1, 1, acc);
    check("cnt_clr_only", sat_cnt, 0);

    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 3) != 0, rand_full(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, acc);
    repeat (6) cycle(0, '0, 1, 0, acc);
    check("drain_empty", q_exp.size(), 0);

    // Reset with buffered words and a nonzero counter.
    cycle(1, sat_word, 0, 0, acc);
    cycle(1, sat_word, 0, 0, acc);
    cycle(0, '0, 0, 0, acc);
    check("pre_rst_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_sat_cnt", sat_cnt, 0);
    check("async_in_ready", in_ready, 0);
    q_exp.delete();
    model_cnt = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    repeat (5) cycle(0, '0, 1, 0, acc);
    check("post_rst_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
